// File: rtl/rgb_seq_pkg.sv
// Shared types, palette and helpers for the RGB fade sequencer.
// Channel order inside a 24-bit color is {R, G, B}.
package rgb_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FADE = 2'd1,
      HOLD = 2'd2
   } seq_state_t;

   localparam int NUM_COLORS = 6;

   // Entry 0 sits in the least significant slice: PALETTE[0] = red.
   localparam logic [NUM_COLORS-1:0][23:0] PALETTE = {
      24'hFF00FF,
      24'h0000FF,
      24'h00FFFF,
      24'h00FF00,
      24'hFFFF00,
      24'hFF0000
   };

   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [7:0] res;
      res = cur;
      if (cur < tgt) begin
         res = cur + 8'd1;
      end else if (cur > tgt) begin
         res = cur - 8'd1;
      end
      return res;
   endfunction

   function automatic logic [2:0] next_color(input logic [2:0] idx);
      logic [2:0] res;
      res = idx + 3'd1;
      if (idx >= 3'(NUM_COLORS - 1)) begin
         res = 3'd0;
      end
      return res;
   endfunction

endpackage

// File: rtl/rgb_pwm.sv
// 8-bit free-running PWM for the three LED channels.
// Each output is a registered (counter < duty) compare, so duty 255 gives 255/256 on.
module rgb_pwm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] duty_r,
   input  logic [7:0] duty_g,
   input  logic [7:0] duty_b,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   logic [7:0] cnt_q;
   logic [2:0] rgb_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         rgb_q <= 3'b000;
      end else begin
         cnt_q <= cnt_q + 8'd1;
         rgb_q <= {(cnt_q < duty_r), (cnt_q < duty_g), (cnt_q < duty_b)};
      end
   end

   assign RGB_R = rgb_q[2];
   assign RGB_G = rgb_q[1];
   assign RGB_B = rgb_q[0];

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps the LED through the palette: linear fade to each color, hold, advance.
// Owns the step prescaler, hold counter, sequencing FSM and duty registers.
module rgb_fade_sequencer
   import rgb_seq_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 12000000,
   parameter int unsigned STEP_CYCLES     = CLOCK_FREQUENCY / 256,
   parameter int unsigned HOLD_STEPS      = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       skip,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic [2:0] color_idx,
   output logic [1:0] state,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);

   seq_state_t       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0][7:0]  duty_q, duty_d, duty_step;
   logic [PW-1:0]    presc_q, presc_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [23:0]      target;
   logic             run, tick, skip_now;

   assign run      = enable && (state_q != IDLE);
   assign tick     = run && (presc_q == PRESC_LAST);
   assign skip_now = skip && run;
   assign target   = PALETTE[idx_q];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         assign duty_step[gi] = step_toward(duty_q[gi], target[gi*8 +: 8]);
      end
   endgenerate

   always_comb begin
      presc_d = presc_q;
      if (run) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Skip takes priority over a coincident tick: the tick's duty step and
   // hold increment are dropped.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = FADE;
            end
         end
         FADE: begin
            if (skip_now) begin
               idx_d  = next_color(idx_q);
               hold_d = '0;
            end else if (tick) begin
               duty_d = duty_step;
               if (duty_step == target) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end
            end
         end
         HOLD: begin
            if (skip_now) begin
               idx_d   = next_color(idx_q);
               state_d = FADE;
               hold_d  = '0;
            end else if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  idx_d   = next_color(idx_q);
                  state_d = FADE;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         duty_q  <= '0;
         presc_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         duty_q  <= duty_d;
         presc_q <= presc_d;
         hold_q  <= hold_d;
      end
   end

   assign duty_r    = duty_q[2];
   assign duty_g    = duty_q[1];
   assign duty_b    = duty_q[0];
   assign color_idx = idx_q;
   assign state     = state_q;

   rgb_pwm u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty_r (duty_q[2]),
      .duty_g (duty_q[1]),
      .duty_b (duty_q[0]),
      .RGB_R  (RGB_R),
      .RGB_G  (RGB_G),
      .RGB_B  (RGB_B)
   );

endmodule
